// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage, fixed-select or round-robin grant.
// Optional packet locking on last_i/last_o is enabled by defining STREAM_MUX_NTO1_LAST_EN.
module stream_mux_nto1 #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        mode_i,
    input  logic [SEL_W-1:0]            sel_i,
    input  logic [NUM_CH-1:0]           valid_i,
    input  logic [NUM_CH*BIT_WIDTH-1:0] data_i,
`ifdef STREAM_MUX_NTO1_LAST_EN
    input  logic [NUM_CH-1:0]           last_i,
    output logic                        last_o,
`endif
    output logic [NUM_CH-1:0]           ready_o,
    output logic                        valid_o,
    output logic [BIT_WIDTH-1:0]        data_o,
    output logic [SEL_W-1:0]            ch_o,
    input  logic                        ready_i
);

    localparam logic [SEL_W:0]   CH_CNT  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]     rr_ptr_r;
    logic                 valid_r;
    logic [BIT_WIDTH-1:0] data_r;
    logic [SEL_W-1:0]     ch_r;

    logic [NUM_CH-1:0]    rot_s;
    logic [SEL_W-1:0]     rr_off_s;
    logic [SEL_W:0]       rr_sum_s;
    logic [SEL_W-1:0]     rr_cand_s;
    logic [SEL_W-1:0]     cand_s;
    logic                 grant_valid_s;
    logic [BIT_WIDTH-1:0] sel_data_s;
    logic                 load_s;
    logic                 xfer_s;
    logic [SEL_W-1:0]     rr_next_s;

`ifdef STREAM_MUX_NTO1_LAST_EN
    logic                 lock_r;
    logic [SEL_W-1:0]     lock_ch_r;
    logic                 last_r;
    logic                 sel_last_s;
`endif

    // Round-robin search: rotate valids so rr_ptr sits at bit 0, find the lowest set bit, rotate back.
    always_comb begin
        rot_s    = NUM_CH'({valid_i, valid_i} >> rr_ptr_r);
        rr_off_s = {SEL_W{1'b0}};
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            rr_off_s = rot_s[k] ? SEL_W'(k) : rr_off_s;
        end
        rr_sum_s  = {1'b0, rr_ptr_r} + {1'b0, rr_off_s};
        rr_cand_s = (rr_sum_s >= CH_CNT) ? SEL_W'(rr_sum_s - CH_CNT) : rr_sum_s[SEL_W-1:0];
    end

    // Candidate channel: an open packet overrides both mode and select.
    always_comb begin
`ifdef STREAM_MUX_NTO1_LAST_EN
        if (lock_r) begin
            cand_s = lock_ch_r;
        end else if (mode_i) begin
            cand_s = rr_cand_s;
        end else begin
            cand_s = sel_i;
        end
`else
        if (mode_i) begin
            cand_s = rr_cand_s;
        end else begin
            cand_s = sel_i;
        end
`endif
    end

    // Grant qualification and payload mux; an out-of-range candidate matches no channel.
    always_comb begin
        grant_valid_s = 1'b0;
        sel_data_s    = {BIT_WIDTH{1'b0}};
`ifdef STREAM_MUX_NTO1_LAST_EN
        sel_last_s    = 1'b0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            grant_valid_s = grant_valid_s | ((cand_s == SEL_W'(k)) & valid_i[k]);
            sel_data_s    = sel_data_s | ({BIT_WIDTH{cand_s == SEL_W'(k)}} & data_i[k*BIT_WIDTH +: BIT_WIDTH]);
`ifdef STREAM_MUX_NTO1_LAST_EN
            sel_last_s    = sel_last_s | ((cand_s == SEL_W'(k)) & last_i[k]);
`endif
        end
    end

    assign load_s    = !valid_r || ready_i;
    assign xfer_s    = load_s && grant_valid_s;
    assign rr_next_s = (cand_s == LAST_CH) ? {SEL_W{1'b0}} : cand_s + SEL_W'(1);

    // Per-channel ready: only the granted channel sees ready, never during reset.
    always_comb begin
        ready_o = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            ready_o[k] = xfer_s && (cand_s == SEL_W'(k)) && !rst_i;
        end
    end

    // Output beat register: replace on transfer, drain to empty when nothing is granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            data_r  <= {BIT_WIDTH{1'b0}};
            ch_r    <= {SEL_W{1'b0}};
`ifdef STREAM_MUX_NTO1_LAST_EN
            last_r  <= 1'b0;
`endif
        end else if (load_s) begin
            if (grant_valid_s) begin
                valid_r <= 1'b1;
                data_r  <= sel_data_s;
                ch_r    <= cand_s;
`ifdef STREAM_MUX_NTO1_LAST_EN
                last_r  <= sel_last_s;
`endif
            end else begin
                valid_r <= 1'b0;
            end
        end
    end

    // Arbitration state: pointer moves past the served channel once its beat (or packet) completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r  <= {SEL_W{1'b0}};
`ifdef STREAM_MUX_NTO1_LAST_EN
            lock_r    <= 1'b0;
            lock_ch_r <= {SEL_W{1'b0}};
`endif
        end else if (xfer_s) begin
`ifdef STREAM_MUX_NTO1_LAST_EN
            if (sel_last_s) begin
                rr_ptr_r <= rr_next_s;
                lock_r   <= 1'b0;
            end else begin
                lock_r    <= 1'b1;
                lock_ch_r <= cand_s;
            end
`else
            rr_ptr_r <= rr_next_s;
`endif
        end
    end

    assign valid_o = valid_r;
    assign data_o  = data_r;
    assign ch_o    = ch_r;
`ifdef STREAM_MUX_NTO1_LAST_EN
    assign last_o  = last_r;
`endif

endmodule
